alu_ram_core: RTL and testbench
===============================

Name: alu_ram_core

Overview:
- Datapath core for the 8-bit accumulator CPU: a 256 x 8 single-port synchronous RAM with a tri-state bidirectional data bus, plus a combinational 8-bit ALU.
- The CPU controller drives the RAM address (MAR), control strobes and ALU operands.
- It reads the RAM bus into IR/MBR and takes the ALU result into AC.
- The RAM and ALU share the clock/reset domain but are otherwise independent.

Parameters:
- DATA_WIDTH, 8, RAM word width and ALU operand/result width.
- ADDR_WIDTH, 8, RAM address width; depth = 2**ADDR_WIDTH (256).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_WIDTH  RAM address.
- data  inout  DATA_WIDTH  bidirectional RAM data bus.
- cs  input  1  RAM chip select, active high.
- we  input  1  RAM write enable, active high.
- oe  input  1  RAM output enable, active high.
- alu_a  input  DATA_WIDTH  ALU operand A.
- alu_b  input  DATA_WIDTH  ALU operand B.
- alu_mode  input  4  ALU operation select.
- alu_s  output  DATA_WIDTH  ALU result, combinational.

Behaviour:
- Reset: rst_n low asynchronously clears the read-data register to 0x00. RAM array contents are not reset. alu_s depends only on its inputs.
- Write: at a rising clk edge with cs=1 and we=1, mem[addr] <= data. oe is ignored for writes.
- Read: at a rising clk edge with cs=1 and we=0, rd_q <= mem[addr]. Read latency is 1 cycle.
- Read during write (cs=1, we=1): rd_q <= the value being written (write-through).
- cs=0: no write; rd_q holds its value.
- Bus drive:
  - data = rd_q when cs=1, oe=1 and we=0.
  - Otherwise data is high-Z, so the external master may drive it.
  - The core never drives the bus while we=1.
- Addressing: full 0x00..0xFF range with no wrap logic. Out-of-range addresses cannot occur at ADDR_WIDTH=8.
- ALU (combinational, all results modulo 2**DATA_WIDTH):
  - 0000 pass A
  - 0001 pass B
  - 0010 A+1
  - 0011 A+B
  - 0100 A-B (two's complement)
  - 0101 A&B
  - 0110 A|B
  - 0111 A^B
  - 1000 A<<1, zero fill
  - 1001 A>>1, logical
  - 1111 ~A (B ignored)
  - all other codes produce 0x00
- Arithmetic wraps: 0xFF+0x01=0x00; 0x00-0x01=0xFF.
- Reset mid-read: rd_q goes to 0x00 immediately. If cs=1, oe=1 and we=0, the bus shows 0x00 while rst_n is low.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, adds combinational outputs:
  - alu_zero (alu_s==0)
  - alu_neg (alu_s MSB)
  - alu_carry: carry-out for add/inc; borrow (A<B) for sub; 0 for other modes.
- When undefined, these ports and their logic are absent and the base behaviour is unchanged.

Test Plan:
- Write then read:
  - Write 0x10 to 0x00 and 0x1C to 0x01 (cs=1, we=1, oe=0).
  - Then set we=0, oe=1, addr=0x00.
  - Bus shows 0x10 after the next edge; after addr=0x01 and the next edge it shows 0x1C.
- Bus tri-state:
  - During writes and with cs=0 or oe=0, data is Z and externally driven values are undisturbed.
  - cs=0 with we=1 leaves memory unchanged on readback.
- Boundary:
  - Write 0xA5 to 0xFF and 0x5A to 0x00; read both back with no aliasing.
  - Read-during-write to 0x20 with 0x0A gives rd_q=0x0A.
- ALU:
  - add 0x01+0x0A=0x0B; add 0xFF+0x01=0x00 (carry=1 with ALU_FLAGS_EN).
  - sub 0x0A-0x01=0x09; sub 0x00-0x01=0xFF.
  - and 0xF0&0x3C=0x30; or 0xF0|0x0F=0xFF; not 0x0F -> 0xF0.
  - Unused code 1010 gives 0x00.
- Reset:
  - Read 0x1C so the bus shows it, then pulse rst_n low between edges.
  - Bus shows 0x00 immediately; RAM still returns 0x1C on the next read after reset.
- Program load:
  - Write 34 bytes (0x00..0x21) of an accumulator program.
  - Read all back sequentially; every byte matches.

Source files
------------

// File: rtl/alu_ram_core.sv
// ============================================================================
//  Module   : alu_ram_core
//  Brief    : 256x8 single-port synchronous RAM on a tri-state data bus plus a
//             combinational 8-bit ALU. Optional flag outputs: ALU_FLAGS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ram_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] alu_a,
    input  logic [DATA_WIDTH-1:0] alu_b,
    input  logic [3:0]            alu_mode,
`ifdef ALU_FLAGS_EN
    output logic                  alu_zero,
    output logic                  alu_neg,
    output logic                  alu_carry,
`endif
    output logic [DATA_WIDTH-1:0] alu_s
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [3:0] MODE_PASS_A = 4'b0000;
    localparam logic [3:0] MODE_PASS_B = 4'b0001;
    localparam logic [3:0] MODE_INC    = 4'b0010;
    localparam logic [3:0] MODE_ADD    = 4'b0011;
    localparam logic [3:0] MODE_SUB    = 4'b0100;
    localparam logic [3:0] MODE_AND    = 4'b0101;
    localparam logic [3:0] MODE_OR     = 4'b0110;
    localparam logic [3:0] MODE_XOR    = 4'b0111;
    localparam logic [3:0] MODE_SHL    = 4'b1000;
    localparam logic [3:0] MODE_SHR    = 4'b1001;
    localparam logic [3:0] MODE_NOT    = 4'b1111;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;

    // Array has no reset so it maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (cs && we) begin
            mem[addr] <= data;
        end
    end

    // Write-through: a write cycle also loads the written value into rd_q.
    always_comb begin
        rd_d = rd_q;
        if (cs) begin
            rd_d = we ? data : mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign data = (cs && oe && !we) ? rd_q : 'z;

    always_comb begin
        alu_s = '0;
        case (alu_mode)
            MODE_PASS_A: alu_s = alu_a;
            MODE_PASS_B: alu_s = alu_b;
            MODE_INC:    alu_s = alu_a + 1'b1;
            MODE_ADD:    alu_s = alu_a + alu_b;
            MODE_SUB:    alu_s = alu_a - alu_b;
            MODE_AND:    alu_s = alu_a & alu_b;
            MODE_OR:     alu_s = alu_a | alu_b;
            MODE_XOR:    alu_s = alu_a ^ alu_b;
            MODE_SHL:    alu_s = alu_a << 1;
            MODE_SHR:    alu_s = alu_a >> 1;
            MODE_NOT:    alu_s = ~alu_a;
            default:     alu_s = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    assign alu_zero = (alu_s == '0);
    assign alu_neg  = alu_s[DATA_WIDTH-1];

    // A modular sum wrapped exactly when it came out smaller than operand A.
    always_comb begin
        alu_carry = 1'b0;
        case (alu_mode)
            MODE_INC: alu_carry = (alu_a == {DATA_WIDTH{1'b1}});
            MODE_ADD: alu_carry = (alu_s < alu_a);
            MODE_SUB: alu_carry = (alu_a < alu_b);
            default:  alu_carry = 1'b0;
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_ram_core.sv
// ============================================================================
//  Module   : tb_alu_ram_core
//  Brief    : Directed self-checking bench for alu_ram_core (RAM bus + ALU).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ram_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    wire  [7:0] data;
    logic       cs;
    logic       we;
    logic       oe;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_mode;
    logic [7:0] alu_s;
`ifdef ALU_FLAGS_EN
    logic       alu_zero;
    logic       alu_neg;
    logic       alu_carry;
`endif

    logic [7:0] tb_drv;
    logic       tb_en;
    assign data = tb_en ? tb_drv : 'z;

    int n_checks = 0;
    int n_errors = 0;

    alu_ram_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data     (data),
        .cs       (cs),
        .we       (we),
        .oe       (oe),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_mode (alu_mode),
`ifdef ALU_FLAGS_EN
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .alu_carry(alu_carry),
`endif
        .alu_s    (alu_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; tb_drv = d; tb_en = 1'b1;
        cs = 1'b1; we = 1'b1; oe = 1'b0;
        tick();
    endtask

    task automatic ram_read(input logic [7:0] a, input string tag, input logic [7:0] exp);
        tb_en = 1'b0;
        addr = a; cs = 1'b1; we = 1'b0; oe = 1'b1;
        tick();
        check_eq(tag, data, exp);
    endtask

    task automatic alu_chk(input string tag, input logic [3:0] m, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp);
        alu_mode = m; alu_a = a; alu_b = b;
        #1;
        check_eq(tag, alu_s, exp);
    endtask

    logic [7:0] prog [34] = '{
        8'h10, 8'h1C, 8'h30, 8'h1D, 8'h50, 8'h1E, 8'h20, 8'h1F,
        8'h70, 8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h80, 8'h7F,
        8'h3C, 8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
        8'hDE, 8'hF0, 8'h0F, 8'hE1, 8'h2D, 8'h4B, 8'h69, 8'h87,
        8'hB4, 8'hD2
    };

    initial begin
        rst_n = 1'b0; addr = 8'h00; cs = 1'b1; we = 1'b0; oe = 1'b1;
        tb_en = 1'b0; tb_drv = 8'h00;
        alu_a = 8'h00; alu_b = 8'h00; alu_mode = 4'h0;
        #12;
        check_eq("reset_bus", data, 8'h00);
        cs = 1'b0;
        #1 rst_n = 1'b1;
        tick();

        // Write then read
        ram_write(8'h00, 8'h10);
        check_eq("bus_during_write", data, 8'h10);
        ram_write(8'h01, 8'h1C);
        ram_read(8'h00, "rd_00", 8'h10);
        ram_read(8'h01, "rd_01", 8'h1C);

        // Bus released when not selected / not enabled
        tb_en = 1'b1; tb_drv = 8'h3C; cs = 1'b0; we = 1'b0; oe = 1'b1;
        #1 check_eq("bus_cs0", data, 8'h3C);
        tb_drv = 8'h99; cs = 1'b1; oe = 1'b0;
        #1 check_eq("bus_oe0", data, 8'h99);
        addr = 8'h00; tb_drv = 8'h77; cs = 1'b0; we = 1'b1;
        tick();
        ram_read(8'h00, "cs0_no_write", 8'h10);

        // Boundary addresses and write-through
        ram_write(8'hFF, 8'hA5);
        ram_write(8'h00, 8'h5A);
        ram_read(8'hFF, "rd_ff", 8'hA5);
        ram_read(8'h00, "rd_00_alias", 8'h5A);
        ram_write(8'h20, 8'h0A);
        tb_en = 1'b0; we = 1'b0; oe = 1'b1; addr = 8'h00;
        #1 check_eq("rd_during_wr", data, 8'h0A);
        ram_read(8'h20, "rd_20", 8'h0A);

        // ALU
        alu_chk("add",      4'b0011, 8'h01, 8'h0A, 8'h0B);
`ifdef ALU_FLAGS_EN
        check_eq("add_nc",  {7'b0, alu_carry}, 8'h00);
`endif
        alu_chk("add_wrap", 4'b0011, 8'hFF, 8'h01, 8'h00);
`ifdef ALU_FLAGS_EN
        check_eq("add_c",   {7'b0, alu_carry}, 8'h01);
        check_eq("add_z",   {7'b0, alu_zero},  8'h01);
`endif
        alu_chk("sub",      4'b0100, 8'h0A, 8'h01, 8'h09);
        alu_chk("sub_wrap", 4'b0100, 8'h00, 8'h01, 8'hFF);
`ifdef ALU_FLAGS_EN
        check_eq("sub_b",   {7'b0, alu_carry}, 8'h01);
        check_eq("sub_n",   {7'b0, alu_neg},   8'h01);
`endif
        alu_chk("and",      4'b0101, 8'hF0, 8'h3C, 8'h30);
        alu_chk("or",       4'b0110, 8'hF0, 8'h0F, 8'hFF);
        alu_chk("xor",      4'b0111, 8'hF0, 8'h3C, 8'hCC);
        alu_chk("not",      4'b1111, 8'h0F, 8'hAA, 8'hF0);
        alu_chk("pass_a",   4'b0000, 8'h5A, 8'hA5, 8'h5A);
        alu_chk("pass_b",   4'b0001, 8'h5A, 8'hA5, 8'hA5);
        alu_chk("inc",      4'b0010, 8'h7F, 8'h00, 8'h80);
        alu_chk("inc_wrap", 4'b0010, 8'hFF, 8'h00, 8'h00);
`ifdef ALU_FLAGS_EN
        check_eq("inc_c",   {7'b0, alu_carry}, 8'h01);
`endif
        alu_chk("shl",      4'b1000, 8'h81, 8'h00, 8'h02);
        alu_chk("shr",      4'b1001, 8'h81, 8'h00, 8'h40);
        alu_chk("unused_a", 4'b1010, 8'hFF, 8'hFF, 8'h00);
        alu_chk("unused_e", 4'b1110, 8'h12, 8'h34, 8'h00);

        // Reset mid-read
        ram_read(8'h01, "rd_01_pre_rst", 8'h1C);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_bus", data, 8'h00);
        #1 rst_n = 1'b1;
        ram_read(8'h01, "rd_01_post_rst", 8'h1C);

        // Program load and readback
        for (int i = 0; i < 34; i++) begin
            ram_write(8'(i), prog[i]);
        end
        for (int i = 0; i < 34; i++) begin
            ram_read(8'(i), $sformatf("prog_%02h", i), prog[i]);
        end

        cs = 1'b0; tb_en = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
